cache_controller: RTL and testbench

- Two-way set-associative, write-through, read-allocate data cache controller in the MEM stage, between the pipeline's memory request and the SRAM controller.
- Owns the tag/valid/data/LRU arrays and performs the hit lookup.
- Serves read hits in the request cycle and runs an FSM for read-miss fills and SRAM write-throughs.
- Drives a ready line that freezes the pipeline while the cache is busy.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/cache_set_array.sv | 53 +++++
 rtl/cache_controller.sv | 174 +++++++++++++++++
 tb/tb_cache_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the
// two-way set-associative write-through data cache.
package cache_pkg;
  localparam int SETS   = 64;
  localparam int TAG_W  = 10;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 3;
  localparam int LINE_W = 64;
  localparam int WORD_W = 32;
  localparam logic [31:0] BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } cache_state_t;

  function automatic logic [31:0] rel_addr(input logic [31:0] addr);
    return addr - BASE_ADDR;
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[OFF_W+IDX_W +: TAG_W];
  endfunction

  // Bit 2 picks the upper or lower 32-bit word of a 64-bit line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic               sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction
endpackage

// File: rtl/cache_set_array.sv
// Two-way tag/valid/line storage: synchronous fill and invalidate,
// combinational read of both ways at one index.
module cache_set_array
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       i_rd_idx,
  output logic [1:0]             o_valid,
  output logic [1:0][TAG_W-1:0]  o_tag,
  output logic [1:0][LINE_W-1:0] o_line,
  input  logic                   i_inv_en,
  input  logic                   i_inv_way,
  input  logic [IDX_W-1:0]       i_inv_idx,
  input  logic                   i_fill_en,
  input  logic                   i_fill_way,
  input  logic [IDX_W-1:0]       i_fill_idx,
  input  logic [TAG_W-1:0]       i_fill_tag,
  input  logic [LINE_W-1:0]      i_fill_line
);
  logic [1:0]        r_valid [SETS];
  logic [TAG_W-1:0]  r_tag   [2][SETS];
  logic [LINE_W-1:0] r_line  [2][SETS];

  // Valid bits are the only state that needs clearing on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= 2'b00;
      end
    end else begin
      if (i_inv_en) begin
        r_valid[i_inv_idx][i_inv_way] <= 1'b0;
      end
      if (i_fill_en) begin
        r_valid[i_fill_idx][i_fill_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_fill_way][i_fill_idx]  <= i_fill_tag;
      r_line[i_fill_way][i_fill_idx] <= i_fill_line;
    end
  end

  assign o_valid   = r_valid[i_rd_idx];
  assign o_tag[0]  = r_tag[0][i_rd_idx];
  assign o_tag[1]  = r_tag[1][i_rd_idx];
  assign o_line[0] = r_line[0][i_rd_idx];
  assign o_line[1] = r_line[1][i_rd_idx];
endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, read-allocate data cache controller
// sitting between the MEM-stage request and the SRAM controller.
module cache_controller
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [31:0]       sram_address,
  output logic [31:0]       sram_wdata,
  output logic              sram_r_en,
  output logic              sram_w_en,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready
);
  cache_state_t r_state;
  cache_state_t w_next;
  logic [SETS-1:0] r_lru;
  logic [31:3]     r_line_addr;
  logic            r_word;

  logic [31:0]             w_a;
  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic [IDX_W-1:0]        w_miss_idx;
  logic [TAG_W-1:0]        w_miss_tag;
  logic [IDX_W-1:0]        w_rd_idx;
  logic [1:0]              w_valid;
  logic [1:0][TAG_W-1:0]   w_tag_rd;
  logic [1:0][LINE_W-1:0]  w_line_rd;
  logic                    w_hit0;
  logic                    w_hit1;
  logic                    w_hit;
  logic                    w_latch;
  logic                    w_inv_en;
  logic                    w_fill_en;
  logic                    w_fill_way;
  logic                    w_lru_we;
  logic [IDX_W-1:0]        w_lru_idx;
  logic                    w_lru_val;

  assign w_a        = rel_addr(address);
  assign w_idx      = addr_index(w_a);
  assign w_tag      = addr_tag(w_a);
  assign w_miss_idx = r_line_addr[OFF_W +: IDX_W];
  assign w_miss_tag = r_line_addr[OFF_W+IDX_W +: TAG_W];
  // During a fill the latched index drives the arrays so the set cannot shift.
  assign w_rd_idx   = (r_state == READ_MISS) ? w_miss_idx : w_idx;

  assign w_hit0 = w_valid[0] & (w_tag_rd[0] == w_tag);
  assign w_hit1 = w_valid[1] & (w_tag_rd[1] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;

  always_comb begin
    if (!w_valid[0]) begin
      w_fill_way = 1'b0;
    end else if (!w_valid[1]) begin
      w_fill_way = 1'b1;
    end else begin
      w_fill_way = r_lru[w_miss_idx];
    end
  end

  cache_set_array u_arrays (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (w_rd_idx),
    .o_valid     (w_valid),
    .o_tag       (w_tag_rd),
    .o_line      (w_line_rd),
    .i_inv_en    (w_inv_en),
    .i_inv_way   (w_hit1),
    .i_inv_idx   (w_idx),
    .i_fill_en   (w_fill_en),
    .i_fill_way  (w_fill_way),
    .i_fill_idx  (w_miss_idx),
    .i_fill_tag  (w_miss_tag),
    .i_fill_line (sram_rdata)
  );

  // Next-state, handshake outputs and array/LRU update strobes.
  always_comb begin
    w_next       = r_state;
    ready        = 1'b0;
    rdata        = 32'd0;
    sram_address = 32'd0;
    sram_wdata   = 32'd0;
    sram_r_en    = 1'b0;
    sram_w_en    = 1'b0;
    w_latch      = 1'b0;
    w_inv_en     = 1'b0;
    w_fill_en    = 1'b0;
    w_lru_we     = 1'b0;
    w_lru_idx    = w_idx;
    w_lru_val    = 1'b0;
    if (rst) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_w_en) begin
            w_next   = WRITE;
            w_inv_en = w_hit;
          end else if (mem_r_en) begin
            if (w_hit) begin
              ready     = 1'b1;
              rdata     = line_word(w_hit1 ? w_line_rd[1] : w_line_rd[0], w_a[2]);
              w_lru_we  = 1'b1;
              w_lru_val = w_hit0;
            end else begin
              w_next  = READ_MISS;
              w_latch = 1'b1;
            end
          end else begin
            ready = 1'b1;
          end
        end
        READ_MISS: begin
          sram_r_en    = 1'b1;
          sram_address = {r_line_addr, 3'b000};
          if (sram_ready) begin
            ready     = 1'b1;
            rdata     = line_word(sram_rdata, r_word);
            w_fill_en = 1'b1;
            w_lru_we  = 1'b1;
            w_lru_idx = w_miss_idx;
            w_lru_val = ~w_fill_way;
            w_next    = IDLE;
          end else begin
            w_next = READ_MISS;
          end
        end
        WRITE: begin
          sram_w_en    = 1'b1;
          sram_address = w_a;
          sram_wdata   = wdata;
          if (sram_ready) begin
            ready  = 1'b1;
            w_next = IDLE;
          end else begin
            w_next = WRITE;
          end
        end
        default: begin
          w_next = IDLE;
        end
      endcase
    end
  end

  // State, LRU bits and the miss address latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lru       <= '0;
      r_line_addr <= '0;
      r_word      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_lru_we) begin
        r_lru[w_lru_idx] <= w_lru_val;
      end
      if (w_latch) begin
        r_line_addr <= w_a[31:3];
        r_word      <= w_a[2];
      end
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: directed scenarios plus random traffic checked against
// a per-set two-way reference model of the cache.
module tb_cache_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [63:0] sram_rdata = 64'd0;
  logic        sram_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model: per set, two ways of {valid, tag, line}, plus the LRU way number.
  bit          m_valid [64][2];
  int          m_tag   [64][2];
  logic [63:0] m_line  [64][2];
  int          m_lru   [64];

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_r_en    (sram_r_en),
    .sram_w_en    (sram_w_en),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input int s, input int t);
    for (int w = 0; w < 2; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == t) return w;
    end
    return -1;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 64; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
      m_lru[s] = 0;
    end
  endtask

  task automatic read_op(input logic [31:0] addr, input logic [63:0] line, input int lat);
    logic [31:0] a;
    int s, t, w, hw, fw;
    logic [63:0] ln;
    a  = addr - 32'd1024;
    s  = int'((a >> 3) % 64);
    t  = int'((a >> 9) % 1024);
    w  = int'((a >> 2) % 2);
    hw = m_find(s, t);
    @(negedge clk);
    mem_r_en = 1'b1; mem_w_en = 1'b0; address = addr; sram_ready = 1'b0;
    #1;
    chk("rd_ready_first", ready, (hw >= 0));
    if (hw >= 0) begin
      ln = m_line[s][hw];
      chk("rd_hit_data", rdata, (w != 0) ? ln[63:32] : ln[31:0]);
      chk("rd_hit_no_sram", {sram_r_en, sram_w_en}, 2'b00);
      m_lru[s] = 1 - hw;
    end else begin
      @(negedge clk); #1;
      for (int i = 0; i <= lat; i++) begin
        chk("rd_miss_r_en", sram_r_en, 1'b1);
        chk("rd_miss_addr", sram_address, a & 32'hFFFF_FFF8);
        chk("rd_miss_wait", ready, 1'b0);
        if (i < lat) begin
          @(negedge clk); #1;
        end
      end
      sram_rdata = line; sram_ready = 1'b1;
      #1;
      chk("rd_fill_ready", ready, 1'b1);
      chk("rd_fill_data", rdata, (w != 0) ? line[63:32] : line[31:0]);
      if (!m_valid[s][0]) fw = 0;
      else if (!m_valid[s][1]) fw = 1;
      else fw = m_lru[s];
      m_valid[s][fw] = 1'b1;
      m_tag[s][fw]   = t;
      m_line[s][fw]  = line;
      m_lru[s]       = 1 - fw;
    end
  endtask

  task automatic write_op(input logic [31:0] addr, input logic [31:0] data,
                          input logic both, input int lat);
    logic [31:0] a;
    int s, t, hw;
    a  = addr - 32'd1024;
    s  = int'((a >> 3) % 64);
    t  = int'((a >> 9) % 1024);
    hw = m_find(s, t);
    @(negedge clk);
    mem_w_en = 1'b1; mem_r_en = both; address = addr; wdata = data; sram_ready = 1'b0;
    #1;
    chk("wr_entry_ready", ready, 1'b0);
    chk("wr_entry_no_r_en", sram_r_en, 1'b0);
    if (hw >= 0) m_valid[s][hw] = 1'b0;
    @(negedge clk); #1;
    for (int i = 0; i <= lat; i++) begin
      chk("wr_w_en", sram_w_en, 1'b1);
      chk("wr_no_r_en", sram_r_en, 1'b0);
      chk("wr_addr", sram_address, a);
      chk("wr_data", sram_wdata, data);
      chk("wr_wait", ready, 1'b0);
      if (i < lat) begin
        @(negedge clk); #1;
      end
    end
    sram_ready = 1'b1;
    #1;
    chk("wr_done_ready", ready, 1'b1);
  endtask

  task automatic idle_op();
    @(negedge clk);
    mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'($urandom_range(0, 1));
    #1;
    chk("idle_ready", ready, 1'b1);
    chk("idle_no_sram", {sram_r_en, sram_w_en}, 2'b00);
  endtask

  task automatic reset_op();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", ready, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_enables", {sram_r_en, sram_w_en}, 2'b00);
    chk("rst_sram_addr", sram_address, 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    m_clear();
    @(negedge clk);
    rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0;
    #1;
    chk("post_rst_ready", ready, 1'b1);
    chk("post_rst_no_sram", {sram_r_en, sram_w_en}, 2'b00);
  endtask

  initial begin
    logic [31:0] addr;
    int sel, idx, tg;
    m_clear();
    reset_op();

    // Directed: fill, hit on other word, replacement and invalidate-on-write.
    read_op(32'd1024 + 32'h48,  64'hBBBB_BBBB_AAAA_AAAA, 1);
    read_op(32'd1024 + 32'h4C,  64'h0, 0);
    read_op(32'd1024 + 32'h248, 64'h2222_2222_1111_1111, 0);
    read_op(32'd1024 + 32'h48,  64'h0, 0);
    read_op(32'd1024 + 32'h448, 64'h4444_4444_3333_3333, 2);
    read_op(32'd1024 + 32'h248, 64'h6666_6666_5555_5555, 0);
    write_op(32'd1024 + 32'h48, 32'h1234_5678, 1'b0, 2);
    read_op(32'd1024 + 32'h48,  64'h8888_8888_7777_7777, 0);
    write_op(32'd1024 + 32'h4C, 32'hCAFE_F00D, 1'b1, 1);
    idle_op();
    read_op(32'd1024 + 32'h1F8, 64'hDDDD_DDDD_CCCC_CCCC, 0);
    read_op(32'd1024 + 32'h000, 64'hFFFF_FFFF_EEEE_EEEE, 0);
    read_op(32'd1024 + 32'h1FC, 64'h0, 0);
    read_op(32'd1024 + 32'h004, 64'h0, 0);

    // Reset in the middle of a miss abandons the fill and clears residency.
    @(negedge clk);
    mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'd1024 + 32'h88; sram_ready = 1'b0;
    #1;
    chk("mid_miss_entry", ready, 1'b0);
    @(negedge clk); #1;
    chk("mid_miss_r_en", sram_r_en, 1'b1);
    reset_op();
    read_op(32'd1024 + 32'h1F8, 64'h0102_0304_0506_0708, 1);

    // Random traffic over a few hot sets (including 0 and 63) and four tags.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 3);
      idx = (sel == 0) ? 0 : (sel == 1) ? 63 : (sel == 2) ? 9 : $urandom_range(0, 63);
      tg  = $urandom_range(0, 3);
      addr = 32'd1024 + 32'(tg * 512 + idx * 8) + 32'($urandom_range(0, 7));
      sel = $urandom_range(0, 19);
      if (sel < 12) begin
        read_op(addr, {$urandom, $urandom}, $urandom_range(0, 3));
      end else if (sel < 17) begin
        write_op(addr, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end else if (sel < 19) begin
        idle_op();
      end else begin
        reset_op();
      end
    end
    idle_op();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
